// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// FSM state encoding, stage indices, NOP word and register-match helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } hz_state_e;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // addi x0, x0, 0 -- what flushed stage registers are loaded with
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic src_hit(
        input logic [4:0] src,
        input logic       used,
        input logic [4:0] rd
    );
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/hazard_wdog_cnt.sv
// Saturating stall-cycle counter plus memory-wait watchdog.
// Ports: stall_i (count enable), in_wait_i (FSM in MEM_WAIT), stall_cnt_o, wdog_err_o (sticky).
module hazard_wdog_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             in_wait_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             wdog_err_o
);

    localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WD_MAX  = WDOG_W'(WDOG_CYCLES);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WDOG_W-1:0] wd_q, wd_d;
    logic              err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Counter only runs while waiting; any other state clears it.
        wd_d  = '0;
        err_d = err_q;
        if (in_wait_i) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            // This cycle completes the WDOG_CYCLES-th wait cycle.
            if (wd_q == WD_LAST) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign stall_cnt_o = cnt_q;
    assign wdog_err_o  = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MDU, memory waits, redirects, traps.
// Inputs: ID/EX register info, MDU/MEM handshakes, redirect/trap; outputs: stage stalls/flushes, busy, perf counter, watchdog flag.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_rd_en_i,
    input  logic             ex_inst_is_load_i,
    input  logic             ex_mdu_start_i,
    input  logic             ex_mdu_done_i,
    input  logic             mem_req_i,
    input  logic             mem_done_i,
    input  logic             redirect_i,
    input  logic             trap_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_mem_o,
    output logic             bubble_ex_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             wdog_err_o
);

    hz_state_e state_q, state_d;

    logic load_use;
    logic s_if, s_id, s_ex, s_mem;
    logic f_id, f_ex, f_mem, bub;

    assign load_use = ex_rd_en_i && ex_inst_is_load_i
                   && (ex_rd_addr_i != 5'd0)
                   && (src_hit(id_rs1_addr_i, id_rs1_used_i, ex_rd_addr_i)
                    || src_hit(id_rs2_addr_i, id_rs2_used_i, ex_rd_addr_i));

    always_comb begin
        state_d = state_q;
        s_if    = 1'b0;
        s_id    = 1'b0;
        s_ex    = 1'b0;
        s_mem   = 1'b0;
        f_id    = 1'b0;
        f_ex    = 1'b0;
        f_mem   = 1'b0;
        bub     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (trap_i) begin
                    {f_id, f_ex, f_mem} = 3'b111;
                    state_d = ST_FLUSH;
                end else if (mem_req_i && !mem_done_i) begin
                    {s_if, s_id, s_ex, s_mem} = 4'b1111;
                    state_d = ST_MEM_WAIT;
                end else if (ex_mdu_start_i && !ex_mdu_done_i) begin
                    {s_if, s_id, s_ex} = 3'b111;
                    f_mem   = 1'b1;
                    state_d = ST_MDU_WAIT;
                end else if (redirect_i) begin
                    {f_id, f_ex} = 2'b11;
                end else if (load_use) begin
                    // Next cycle the load is in MEM, so this self-clears.
                    {s_if, s_id, bub} = 3'b111;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_done_i) begin
                    state_d = ST_RUN;
                end else begin
                    {s_if, s_id, s_ex, s_mem} = 4'b1111;
                end
            end
            ST_MDU_WAIT: begin
                if (ex_mdu_done_i) begin
                    state_d = ST_RUN;
                end else begin
                    {s_if, s_id, s_ex} = 3'b111;
                    f_mem = 1'b1;
                end
            end
            ST_FLUSH: begin
                {f_id, f_ex} = 2'b11;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign stall_if_o  = rst_n & s_if;
    assign stall_id_o  = rst_n & s_id;
    assign stall_ex_o  = rst_n & s_ex;
    assign stall_mem_o = rst_n & s_mem;
    assign flush_id_o  = rst_n & f_id;
    assign flush_ex_o  = rst_n & f_ex;
    assign flush_mem_o = rst_n & f_mem;
    assign bubble_ex_o = rst_n & bub;
    assign busy_o      = rst_n & (state_q != ST_RUN);

    hazard_wdog_cnt #(
        .CNT_W       (CNT_W),
        .WDOG_CYCLES (WDOG_CYCLES),
        .WDOG_W      (WDOG_W)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall_if_o),
        .in_wait_i   (state_q == ST_MEM_WAIT),
        .stall_cnt_o (stall_cnt_o),
        .wdog_err_o  (wdog_err_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Output vector order: stall_if,id,ex,mem, flush_id,ex,mem, bubble_ex, busy.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_used, id_rs2_used, ex_rd_en, ex_is_load;
    logic        mdu_start, mdu_done, mem_req, mem_done, redirect, trap;
    logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, bub, busy;
    logic [31:0] stall_cnt;
    logic        wdog_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt;

    localparam logic [8:0] O_IDLE  = 9'b0000_000_0_0;
    localparam logic [8:0] O_LU    = 9'b1100_000_1_0;
    localparam logic [8:0] O_MDU0  = 9'b1110_001_0_0;
    localparam logic [8:0] O_MDUW  = 9'b1110_001_0_1;
    localparam logic [8:0] O_MEM0  = 9'b1111_000_0_0;
    localparam logic [8:0] O_MEMW  = 9'b1111_000_0_1;
    localparam logic [8:0] O_DONE  = 9'b0000_000_0_1;
    localparam logic [8:0] O_TRAP  = 9'b0000_111_0_0;
    localparam logic [8:0] O_FLUSH = 9'b0000_110_0_1;
    localparam logic [8:0] O_REDIR = 9'b0000_110_0_0;

    wire [8:0] outs = {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, bub, busy};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .CNT_W       (32),
        .WDOG_CYCLES (8),
        .WDOG_W      (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1_addr_i     (id_rs1_addr),
        .id_rs2_addr_i     (id_rs2_addr),
        .id_rs1_used_i     (id_rs1_used),
        .id_rs2_used_i     (id_rs2_used),
        .ex_rd_addr_i      (ex_rd_addr),
        .ex_rd_en_i        (ex_rd_en),
        .ex_inst_is_load_i (ex_is_load),
        .ex_mdu_start_i    (mdu_start),
        .ex_mdu_done_i     (mdu_done),
        .mem_req_i         (mem_req),
        .mem_done_i        (mem_done),
        .redirect_i        (redirect),
        .trap_i            (trap),
        .stall_if_o        (s_if),
        .stall_id_o        (s_id),
        .stall_ex_o        (s_ex),
        .stall_mem_o       (s_mem),
        .flush_id_o        (f_id),
        .flush_ex_o        (f_ex),
        .flush_mem_o       (f_mem),
        .bubble_ex_o       (bub),
        .busy_o            (busy),
        .stall_cnt_o       (stall_cnt),
        .wdog_err_o        (wdog_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd_en = 1'b0; ex_is_load = 1'b0;
        mdu_start = 1'b0; mdu_done = 1'b0;
        mem_req = 1'b0; mem_done = 1'b0;
        redirect = 1'b0; trap = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] r1,
                                input logic u1, input logic [4:0] r2,
                                input logic u2);
        ex_rd_addr = rd; ex_rd_en = 1'b1; ex_is_load = 1'b1;
        id_rs1_addr = r1; id_rs1_used = u1;
        id_rs2_addr = r2; id_rs2_used = u2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_inputs();
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        mem_req = 1'b1;
        #12;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_outs got %b exp %b", outs, O_IDLE);
        end
        checks++;
        if (stall_cnt !== 32'd0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%b exp 0/0", stall_cnt, wdog_err);
        end
        tick();
        clr_inputs();
        rst_n = 1'b1;
        exp_cnt = 32'd0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL post_reset got %b exp %b", outs, O_IDLE);
        end
    endtask

    task automatic test_load_use();
        logic [8:0] exp_o [4];
        exp_o[0] = O_LU; exp_o[1] = O_IDLE; exp_o[2] = O_LU; exp_o[3] = O_IDLE;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
                1: set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
                2: set_load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
                default: set_load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b0);
            endcase
            #1;
            checks++;
            if (outs !== exp_o[k]) begin
                errors++;
                $display("FAIL load_use_%0d got %b exp %b", k, outs, exp_o[k]);
            end
            if (exp_o[k] == O_LU) exp_cnt = exp_cnt + 1;
            tick();
            // Load has advanced to MEM: the hazard disappears.
            ex_is_load = 1'b0;
            #1;
            checks++;
            if (outs !== O_IDLE) begin
                errors++;
                $display("FAIL load_use_after_%0d got %b exp %b", k, outs, O_IDLE);
            end
            clr_inputs();
        end
        checks++;
        if (stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL load_use_cnt got %0d exp %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_mdu();
        int bad = 0;
        mdu_start = 1'b1;
        #1;
        checks++;
        if (outs !== O_MDU0) begin
            errors++;
            $display("FAIL mdu_start got %b exp %b", outs, O_MDU0);
        end
        tick();
        mdu_start = 1'b0;
        for (int i = 1; i < 33; i++) begin
            #1;
            if (outs !== O_MDUW) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mdu_wait got %0d bad cycles exp 0", bad);
        end
        mdu_done = 1'b1;
        #1;
        checks++;
        if (outs !== O_DONE) begin
            errors++;
            $display("FAIL mdu_done got %b exp %b", outs, O_DONE);
        end
        tick();
        mdu_done = 1'b0;
        #1;
        exp_cnt = exp_cnt + 33;
        checks++;
        if (outs !== O_IDLE || stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL mdu_end got %b/%0d exp %b/%0d",
                     outs, stall_cnt, O_IDLE, exp_cnt);
        end
        // Start and done in the same cycle: no stall at all.
        mdu_start = 1'b1; mdu_done = 1'b1;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL mdu_same_cycle got %b exp %b", outs, O_IDLE);
        end
        tick();
        clr_inputs();
    endtask

    task automatic test_mem();
        int bad = 0;
        mem_req = 1'b1;
        #1;
        checks++;
        if (outs !== O_MEM0) begin
            errors++;
            $display("FAIL mem_req got %b exp %b", outs, O_MEM0);
        end
        tick();
        for (int i = 1; i < 5; i++) begin
            trap = (i == 2);
            #1;
            if (outs !== O_MEMW) bad++;
            tick();
        end
        trap = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_wait got %0d bad cycles exp 0", bad);
        end
        mem_done = 1'b1;
        #1;
        checks++;
        if (outs !== O_DONE) begin
            errors++;
            $display("FAIL mem_done got %b exp %b", outs, O_DONE);
        end
        tick();
        clr_inputs();
        #1;
        exp_cnt = exp_cnt + 5;
        checks++;
        if (outs !== O_IDLE || stall_cnt !== exp_cnt || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_end got %b/%0d/%b exp %b/%0d/0",
                     outs, stall_cnt, wdog_err, O_IDLE, exp_cnt);
        end
    endtask

    task automatic test_trap_priority();
        trap = 1'b1; redirect = 1'b1;
        set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (outs !== O_TRAP) begin
            errors++;
            $display("FAIL trap_prio got %b exp %b", outs, O_TRAP);
        end
        tick();
        clr_inputs();
        #1;
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL flush_state got %b exp %b", outs, O_FLUSH);
        end
        tick();
        redirect = 1'b1;
        set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (outs !== O_REDIR) begin
            errors++;
            $display("FAIL redirect_prio got %b exp %b", outs, O_REDIR);
        end
        tick();
        clr_inputs();
        #1;
        checks++;
        if (outs !== O_IDLE || stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL trap_end got %b/%0d exp %b/%0d",
                     outs, stall_cnt, O_IDLE, exp_cnt);
        end
    endtask

    task automatic test_wdog();
        mem_req = 1'b1;
        tick();
        // k counts cycles spent in MEM_WAIT; the flag is set by the
        // edge closing the 8th one, so it is visible from the 9th.
        for (int k = 1; k <= 10; k++) begin
            mem_done = (k == 10);
            #1;
            if (k == 8 || k == 9) begin
                checks++;
                if (wdog_err !== (k == 9)) begin
                    errors++;
                    $display("FAIL wdog_k%0d got %b exp %b", k, wdog_err, k == 9);
                end
            end
            if (k == 10) begin
                checks++;
                if (outs !== O_DONE) begin
                    errors++;
                    $display("FAIL wdog_done got %b exp %b", outs, O_DONE);
                end
            end
            tick();
        end
        clr_inputs();
        tick();
        exp_cnt = exp_cnt + 10;
        checks++;
        if (wdog_err !== 1'b1 || outs !== O_IDLE || stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL wdog_sticky got %b/%b/%0d exp 1/%b/%0d",
                     wdog_err, outs, stall_cnt, O_IDLE, exp_cnt);
        end
    endtask

    task automatic test_reset_midwait();
        mem_req = 1'b1;
        tick();
        checks++;
        if (outs !== O_MEMW) begin
            errors++;
            $display("FAIL midwait_pre got %b exp %b", outs, O_MEMW);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE || stall_cnt !== 32'd0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL midwait_rst got %b/%0d/%b exp %b/0/0",
                     outs, stall_cnt, wdog_err, O_IDLE);
        end
        tick();
        clr_inputs();
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE || stall_cnt !== 32'd0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL midwait_post got %b/%0d/%b exp %b/0/0",
                     outs, stall_cnt, wdog_err, O_IDLE);
        end
        mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL mdu_rst got %b exp %b", outs, O_IDLE);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mdu_rst_post got %b/%0d exp %b/0",
                     outs, stall_cnt, O_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mdu();
        test_mem();
        test_trap_priority();
        test_wdog();
        test_reset_midwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
